muldiv_seq_unit: RTL
====================

Name: muldiv_seq_unit

Overview:
Iterative multiply/divide sequencer serving the EX-stage alu_op codes 12–15 (MUL, MULT, DIV, DIVU), which the single-cycle ALU does not implement.
- Accepts one operation, runs a 32-iteration radix-2 shift-add or restoring-divide loop, and holds the EX stage with a stall until completion.
- Owns the architectural HI/LO registers.
- Sits beside the ALU in EX; its stall output feeds the same stall path the ID hazard logic drives into PC/IF-ID/ID-EX.

Parameters:
DATA_W, 32, operand/result width
CNT_W, 6, iteration counter width (must hold DATA_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start_i  input  1  EX holds a muldiv op this cycle
alu_op_i  input  5  12=MUL, 13=MULT, 14=DIV, 15=DIVU; other codes ignored
src1_i  input  32  operand A / dividend
src2_i  input  32  operand B / divisor
flush_i  input  1  pipeline flush; aborts the operation in flight
hi_we_i  input  1  MTHI write
lo_we_i  input  1  MTLO write
hilo_wdata_i  input  32  MTHI/MTLO data
stall_o  output  1  hold PC, IF-ID, ID-EX
done_o  output  1  one-cycle completion pulse
result_o  output  32  MUL GPR result; valid when done_o=1 and op was MUL
hi_o  output  32  HI register
lo_o  output  32  LO register

Behaviour:
- Reset (rst=0, async): state=IDLE; counter, HI, LO, result_o = 0; done_o=0; stall_o=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 with a valid op latches the op, operand magnitudes, and sign flags.
  - Next state is CALC with count=0.
  - DIV/DIVU with src2_i=0 go directly to DONE instead.
  - Invalid op codes: no action.
- Operand magnitudes: signed ops (MUL, MULT, DIV) use absolute values; DIVU uses raw values.
- CALC, multiply: one shift-add step per cycle; count increments.
- CALC, divide: one restoring-subtract step per cycle; count increments.
- Leaving CALC: after step 32 (count=31 at the edge), apply sign correction and go to DONE.
  - Product sign = s1^s2.
  - Quotient sign = s1^s2.
  - Remainder sign = sign of dividend.
- DONE (exactly one cycle): done_o=1, then return to IDLE.
  - MULT: {HI,LO} = 64-bit product.
  - MUL: result_o = low 32 bits of product; HI/LO unchanged.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - HI/LO update on the edge entering DONE and are visible in DONE.
- Stall: stall_o = (IDLE & start_i & valid op) | CALC. It is combinational, so the issuing cycle is held. stall_o=0 in DONE so the instruction leaves EX.
- Latency: start sampled at cycle k → stall cycles k..k+32 (33 cycles) → done_o at cycle k+33.
- Divide by zero: DONE at k+1 (stall only at cycle k); LO=32'hFFFFFFFF, HI=src1_i.
- Signed overflow: DIV 32'h80000000 / 32'hFFFFFFFF gives LO=32'h80000000, HI=0. This is the natural result of magnitude arithmetic plus sign correction.
- start_i while in CALC/DONE is ignored; no queuing.
- flush_i=1 in any state: next state IDLE, HI/LO/result_o unchanged, done_o not asserted. flush_i beats start_i in the same cycle.
- MTHI/MTLO:
  - hi_we_i/lo_we_i write on the clock edge in IDLE or DONE.
  - In DONE, the completion update already happened; the MT write then overwrites.
  - Writes in CALC are ignored; the pipeline is stalled there.
- Reset asserted mid-CALC: immediate return to reset values; no partial HI/LO update.

Decomposition:
- Shared define include: alu_op codes 12–15 (alu_MUL, alu_MULT, alu_DIV, alu_DIVU, beside the existing alu_* macros) and state encodings st_IDLE/st_CALC/st_DONE.
- One sub-module is natural: muldiv_step. It is the combinational single-iteration datapath (add-shift for multiply, trial-subtract for divide) over a 64-bit accumulator.
- The controller keeps the FSM, counter, sign flags, and HI/LO.

Test Plan:
- MULT src1=32'hFFFFFFFE (-2), src2=3 → stall 33 cycles, done at k+33, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
- DIVU src1=100, src2=7 → LO=14, HI=2.
- DIV src1=-7, src2=2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- MUL src1=32'h00010000, src2=32'h00010000 → result_o=0, HI/LO unchanged from prior values.
- DIV src2=0, src1=55 → done at k+1, LO=32'hFFFFFFFF, HI=55.
- DIVU 100/7 started, flush_i at iteration 10 → IDLE next cycle, no done_o, HI/LO hold old values.
- Re-issue the same DIVU 100/7 with hi_we_i=1, data 32'h1234 during DONE → LO=14, HI=32'h1234.
- rst pulsed low mid-CALC → all outputs 0 asynchronously.

Source files
------------

// File: rtl/muldiv_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit_pkg
//  Description : Shared ALU op codes, FSM state encodings and small helper
//                functions for the iterative multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_seq_unit_pkg;

  // EX-stage ALU op codes served by the sequencer (the single-cycle ALU uses 0-11)
  localparam logic [4:0] c_ALU_MUL  = 5'd12;
  localparam logic [4:0] c_ALU_MULT = 5'd13;
  localparam logic [4:0] c_ALU_DIV  = 5'd14;
  localparam logic [4:0] c_ALU_DIVU = 5'd15;

  // Sequencer FSM encodings
  localparam int         c_STATE_W  = 2;
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CALC  = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  // True for any op code this unit executes
  function automatic logic f_is_muldiv(input logic [4:0] op);
    return (op == c_ALU_MUL) || (op == c_ALU_MULT) ||
           (op == c_ALU_DIV) || (op == c_ALU_DIVU);
  endfunction

  // True for the two divide op codes
  function automatic logic f_is_div(input logic [4:0] op);
    return (op == c_ALU_DIV) || (op == c_ALU_DIVU);
  endfunction

  // DIVU is the only unsigned operation
  function automatic logic f_is_signed(input logic [4:0] op);
    return (op != c_ALU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit_if
//  Description : EX-stage request/response bundle between the pipeline and
//                the multiply/divide sequencer, including MTHI/MTLO writes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [4:0]        alu_op_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              flush_i;
  logic              hi_we_i;
  logic              lo_we_i;
  logic [DATA_W-1:0] hilo_wdata_i;
  logic              stall_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  // Pipeline side: issues operations, observes stall/completion and HI/LO
  modport master (
    output start_i, alu_op_i, src1_i, src2_i, flush_i,
           hi_we_i, lo_we_i, hilo_wdata_i,
    input  stall_o, done_o, result_o, hi_o, lo_o
  );

  // Sequencer side
  modport slave (
    input  start_i, alu_op_i, src1_i, src2_i, flush_i,
           hi_we_i, lo_we_i, hilo_wdata_i,
    output stall_o, done_o, result_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : Combinational single iteration over a 2*DATA_W accumulator.
//                Multiply: {upper, multiplier} shift-add (LSB-first).
//                Divide  : {remainder, dividend} restoring trial-subtract.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  wire logic                i_is_div,
  input  wire logic [2*DATA_W-1:0] i_acc,
  input  wire logic [DATA_W-1:0]   i_opnd,
  output logic      [2*DATA_W-1:0] o_acc
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W-1:0] w_diff;
  logic              w_fits;

  // One multiply or divide step, selected by the latched operation
  always_comb begin
    // Carry out of the add is kept so the 33-bit partial sum shifts in intact
    w_sum    = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + {1'b0, i_opnd};
    // Remainder shifted left with the next dividend bit; needs one extra bit
    w_rem_sh = i_acc[2*DATA_W-1:DATA_W-1];
    w_fits   = (w_rem_sh >= {1'b0, i_opnd});
    // When the subtract succeeds the difference is below the divisor, so
    // modulo arithmetic on the low bits is exact
    w_diff   = w_rem_sh[DATA_W-1:0] - i_opnd;
    o_acc    = i_acc;
    if (i_is_div) begin
      if (w_fits) begin
        o_acc = {w_diff, i_acc[DATA_W-2:0], 1'b1};
      end else begin
        o_acc = {i_acc[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[DATA_W-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*DATA_W-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_unit
//  Description : Iterative MUL/MULT/DIV/DIVU sequencer for the EX stage.
//                Runs 32 radix-2 iterations on operand magnitudes, applies
//                sign correction on the last step, owns HI/LO and stalls the
//                front of the pipeline while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input wire logic         clk,
  input wire logic         rst,
  muldiv_seq_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [4:0]           r_op;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]    r_opnd;
  logic [DATA_W-1:0]    r_hi;
  logic [DATA_W-1:0]    r_lo;
  logic [DATA_W-1:0]    r_result;

  logic                 w_valid_op;
  logic                 w_issue;
  logic                 w_div0;
  logic                 w_signed;
  logic [DATA_W-1:0]    w_abs1;
  logic [DATA_W-1:0]    w_abs2;
  logic [2*DATA_W-1:0]  w_step_acc;
  logic [2*DATA_W-1:0]  w_prod;
  logic [DATA_W-1:0]    w_quo;
  logic [DATA_W-1:0]    w_rem;
  logic                 w_finish;
  logic                 w_stall;
  logic                 w_done;

  // Decode the incoming request and form operand magnitudes
  always_comb begin
    w_valid_op = f_is_muldiv(bus.alu_op_i);
    w_signed   = f_is_signed(bus.alu_op_i);
    w_div0     = f_is_div(bus.alu_op_i) && (bus.src2_i == '0);
    w_issue    = (r_state == c_ST_IDLE) && bus.start_i && w_valid_op && !bus.flush_i;
    w_abs1     = (w_signed && bus.src1_i[DATA_W-1]) ? -bus.src1_i : bus.src1_i;
    w_abs2     = (w_signed && bus.src2_i[DATA_W-1]) ? -bus.src2_i : bus.src2_i;
  end

  muldiv_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_is_div (f_is_div(r_op)),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_step_acc)
  );

  // Sign correction applied to the value produced by the final iteration
  always_comb begin
    w_finish = (r_state == c_ST_CALC) && (r_cnt == c_LAST_CNT) && !bus.flush_i;
    w_prod   = r_neg_q ? -w_step_acc : w_step_acc;
    w_quo    = r_neg_q ? -w_step_acc[DATA_W-1:0] : w_step_acc[DATA_W-1:0];
    w_rem    = r_neg_r ? -w_step_acc[2*DATA_W-1:DATA_W] : w_step_acc[2*DATA_W-1:DATA_W];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; a flush always wins and returns to IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.start_i && w_valid_op) begin
          w_next_state = w_div0 ? c_ST_DONE : c_ST_CALC;
        end
      end
      c_ST_CALC: begin
        if (r_cnt == c_LAST_CNT) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
    if (bus.flush_i) begin
      w_next_state = c_ST_IDLE;
    end
  end

  // FSM outputs; the stall is combinational so the issuing cycle is held
  always_comb begin
    w_stall = ((r_state == c_ST_IDLE) && bus.start_i && w_valid_op) ||
              (r_state == c_ST_CALC);
    w_done  = (r_state == c_ST_DONE) && !bus.flush_i;
  end

  // Datapath: operand latch, iteration, completion write-back and MTHI/MTLO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else begin
      if (w_issue) begin
        r_op    <= bus.alu_op_i;
        r_cnt   <= '0;
        r_neg_q <= w_signed && (bus.src1_i[DATA_W-1] ^ bus.src2_i[DATA_W-1]);
        r_neg_r <= w_signed && bus.src1_i[DATA_W-1];
        if (f_is_div(bus.alu_op_i)) begin
          r_acc  <= {{DATA_W{1'b0}}, w_abs1};
          r_opnd <= w_abs2;
        end else begin
          r_acc  <= {{DATA_W{1'b0}}, w_abs2};
          r_opnd <= w_abs1;
        end
        // Divide by zero skips the loop and completes with fixed values
        if (w_div0) begin
          r_lo <= '1;
          r_hi <= bus.src1_i;
        end
      end else if ((r_state == c_ST_CALC) && !bus.flush_i) begin
        r_acc <= w_step_acc;
        r_cnt <= r_cnt + 1'b1;
        if (w_finish) begin
          case (r_op)
            c_ALU_MULT: {r_hi, r_lo} <= w_prod;
            c_ALU_MUL:  r_result     <= w_prod[DATA_W-1:0];
            default: begin
              r_lo <= w_quo;
              r_hi <= w_rem;
            end
          endcase
        end
      end
      // MT writes land after any completion update, so they overwrite it
      if (((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && !bus.flush_i) begin
        if (bus.hi_we_i) begin
          r_hi <= bus.hilo_wdata_i;
        end
        if (bus.lo_we_i) begin
          r_lo <= bus.hilo_wdata_i;
        end
      end
    end
  end

  assign bus.stall_o  = w_stall;
  assign bus.done_o   = w_done;
  assign bus.result_o = r_result;
  assign bus.hi_o     = r_hi;
  assign bus.lo_o     = r_lo;

endmodule
`default_nettype wire
